// File: rtl/nv_nvdla_cacc_reg_pkg.sv
// Shared definitions for the CACC register-file ping-pong controller.
//   - register offsets for the single-register region and the dual-region bounds
//   - grp_state_e : 2-bit per-group state reported in S_STATUS
//   - cacc_fsm_e  : consumer sequencing FSM state
//   - in_dual_region() : true for offsets routed to a dual register group
package nv_nvdla_cacc_reg_pkg;

    localparam logic [11:0] S_STATUS_OFS    = 12'h000;
    localparam logic [11:0] S_POINTER_OFS   = 12'h004;
    localparam logic [11:0] D_OP_ENABLE_OFS = 12'h008;
    localparam logic [11:0] DUAL_LO_OFS     = 12'h00c;
    localparam logic [11:0] DUAL_HI_OFS     = 12'h034;

    typedef enum logic [1:0] {
        GRP_IDLE    = 2'd0,
        GRP_RUNNING = 2'd1,
        GRP_PENDING = 2'd2
    } grp_state_e;

    typedef enum logic {
        FSM_IDLE   = 1'b0,
        FSM_ACTIVE = 1'b1
    } cacc_fsm_e;

    function automatic logic in_dual_region(input logic [11:0] ofs);
        return (ofs >= DUAL_LO_OFS) && (ofs <= DUAL_HI_OFS);
    endfunction

endpackage

// File: rtl/nv_nvdla_cacc_grp_flag.sv
// One per-group op_en flag and its status encoding.
// Ports:
//   nvdla_core_clk, nvdla_core_rst : clock, synchronous active-high reset
//   set       : request to raise op_en
//   clr       : retire request; wins over set in the same cycle
//   running   : this group is the consumer and the consumer FSM is ACTIVE
//   op_en     : registered flag
//   grp_state : IDLE / RUNNING / PENDING for S_STATUS
module nv_nvdla_cacc_grp_flag
    import nv_nvdla_cacc_reg_pkg::*;
(
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rst,
    input  logic       set,
    input  logic       clr,
    input  logic       running,
    output logic       op_en,
    output grp_state_e grp_state
);

    logic op_en_q;

    // Clear has priority: an enable write landing on the retiring group is
    // lost, because the flag was still 1 when it was sampled.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            op_en_q <= 1'b0;
        end else if (clr) begin
            op_en_q <= 1'b0;
        end else if (set) begin
            op_en_q <= 1'b1;
        end
    end

    always_comb begin
        grp_state = GRP_IDLE;
        if (op_en_q) begin
            grp_state = running ? GRP_RUNNING : GRP_PENDING;
        end
    end

    assign op_en = op_en_q;

endmodule

// File: rtl/nv_nvdla_cacc_regfile_ctrl.sv
// Ping-pong controller between the CSB register port and the two dual
// register groups of CACC. Decodes S_STATUS / S_POINTER / D_OP_ENABLE,
// routes dual-region accesses to the producer group, owns the op_en flags
// and walks the consumer pointer through the groups (launch, retire, irq).
//
// Ports:
//   nvdla_core_clk, nvdla_core_rst    : clock, synchronous active-high reset
//   reg_offset/reg_wr_en/reg_wr_data  : CSB-side register access
//   reg_rd_data                       : combinational read data
//   d0/d1_reg_wr_en, d0/d1_rd_data    : per-group write strobes / read data
//   d0/d1_op_en                       : per-group op_en flags
//   dp_consumer, dp_start, dp_done    : datapath sequencing
//   intr_done                         : per-group retire pulse
//   dbg_fsm_state                     : consumer FSM state (observation only)
//
// Build option: CACC_DUAL_WR_PROTECT_EN drops dual-region writes into an
// enabled producer group and records the drop in sticky S_STATUS[31].
//
// Handshake: dp_start is a one-cycle pulse the cycle after the FSM leaves
// IDLE; dp_done is accepted only in ACTIVE and not while dp_start is high.
module nv_nvdla_cacc_regfile_ctrl
    import nv_nvdla_cacc_reg_pkg::*;
#(
    parameter int GRP_NUM = 2
)
(
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic [11:0] reg_offset,
    input  logic        reg_wr_en,
    input  logic [31:0] reg_wr_data,
    output logic [31:0] reg_rd_data,
    output logic        d0_reg_wr_en,
    output logic        d1_reg_wr_en,
    input  logic [31:0] d0_rd_data,
    input  logic [31:0] d1_rd_data,
    output logic        d0_op_en,
    output logic        d1_op_en,
    output logic        dp_consumer,
    output logic        dp_start,
    input  logic        dp_done,
    output logic [1:0]  intr_done,
    output cacc_fsm_e   dbg_fsm_state
);

    generate
        if (GRP_NUM != 2) begin : g_bad_grp_num
            $error("nv_nvdla_cacc_regfile_ctrl supports GRP_NUM == 2 only");
        end
    endgenerate

    cacc_fsm_e  state_q, state_d;
    logic       producer_q;
    logic       consumer_q, consumer_d;
    logic       dp_start_q, dp_start_d;
    logic [1:0] intr_done_q, intr_done_d;
    logic [1:0] op_en, op_set, op_clr;
    grp_state_e grp_state0, grp_state1;
    logic       in_dual, dual_block, wr_drop, en_wr;

    assign in_dual = in_dual_region(reg_offset);
    assign en_wr   = reg_wr_en && (reg_offset == D_OP_ENABLE_OFS) && reg_wr_data[0];

`ifdef CACC_DUAL_WR_PROTECT_EN
    logic wr_drop_q;
    logic unused_wr_data;

    assign dual_block = op_en[producer_q];

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            wr_drop_q <= 1'b0;
        end else if (reg_wr_en && in_dual && dual_block) begin
            wr_drop_q <= 1'b1;
        end else if (reg_wr_en && (reg_offset == S_STATUS_OFS) && reg_wr_data[31]) begin
            wr_drop_q <= 1'b0;
        end
    end

    assign wr_drop        = wr_drop_q;
    assign unused_wr_data = ^reg_wr_data[30:1];
`else
    logic unused_wr_data;

    assign dual_block     = 1'b0;
    assign wr_drop        = 1'b0;
    assign unused_wr_data = ^reg_wr_data[31:1];
`endif

    // Routing always uses the registered producer pointer.
    assign d0_reg_wr_en = reg_wr_en && in_dual && !producer_q && !dual_block;
    assign d1_reg_wr_en = reg_wr_en && in_dual &&  producer_q && !dual_block;

    // Enable only lands on a group whose flag is currently clear.
    assign op_set[0] = en_wr && !producer_q && !op_en[0];
    assign op_set[1] = en_wr &&  producer_q && !op_en[1];

    nv_nvdla_cacc_grp_flag u_grp0 (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .set            (op_set[0]),
        .clr            (op_clr[0]),
        .running        ((state_q == FSM_ACTIVE) && !consumer_q),
        .op_en          (op_en[0]),
        .grp_state      (grp_state0)
    );

    nv_nvdla_cacc_grp_flag u_grp1 (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .set            (op_set[1]),
        .clr            (op_clr[1]),
        .running        ((state_q == FSM_ACTIVE) && consumer_q),
        .op_en          (op_en[1]),
        .grp_state      (grp_state1)
    );

    always_comb begin
        state_d     = state_q;
        consumer_d  = consumer_q;
        dp_start_d  = 1'b0;
        intr_done_d = 2'b00;
        op_clr      = 2'b00;
        case (state_q)
            FSM_IDLE: begin
                if (op_en[consumer_q]) begin
                    state_d    = FSM_ACTIVE;
                    dp_start_d = 1'b1;
                end
            end
            FSM_ACTIVE: begin
                // A done coinciding with the start pulse belongs to no layer.
                if (dp_done && !dp_start_q) begin
                    op_clr[consumer_q]      = 1'b1;
                    intr_done_d[consumer_q] = 1'b1;
                    consumer_d              = ~consumer_q;
                    state_d                 = FSM_IDLE;
                end
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q     <= FSM_IDLE;
            consumer_q  <= 1'b0;
            dp_start_q  <= 1'b0;
            intr_done_q <= 2'b00;
            producer_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            consumer_q  <= consumer_d;
            dp_start_q  <= dp_start_d;
            intr_done_q <= intr_done_d;
            if (reg_wr_en && (reg_offset == S_POINTER_OFS)) begin
                producer_q <= reg_wr_data[0];
            end
        end
    end

    always_comb begin
        reg_rd_data = 32'd0;
        if (in_dual) begin
            reg_rd_data = producer_q ? d1_rd_data : d0_rd_data;
        end else begin
            case (reg_offset)
                S_STATUS_OFS:    reg_rd_data = {wr_drop, 13'd0, grp_state1, 14'd0, grp_state0};
                S_POINTER_OFS:   reg_rd_data = {15'd0, consumer_q, 15'd0, producer_q};
                D_OP_ENABLE_OFS: reg_rd_data = {31'd0, op_en[producer_q]};
                default:         reg_rd_data = 32'd0;
            endcase
        end
    end

    assign d0_op_en      = op_en[0];
    assign d1_op_en      = op_en[1];
    assign dp_consumer   = consumer_q;
    assign dp_start      = dp_start_q;
    assign intr_done     = intr_done_q;
    assign dbg_fsm_state = state_q;

endmodule

// File: tb/tb_nv_nvdla_cacc_regfile_ctrl.sv
module tb_nv_nvdla_cacc_regfile_ctrl;
    import nv_nvdla_cacc_reg_pkg::*;

`ifdef CACC_DUAL_WR_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] reg_offset;
    logic        reg_wr_en;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;
    logic        d0_reg_wr_en, d1_reg_wr_en;
    logic [31:0] d0_rd_data, d1_rd_data;
    logic        d0_op_en, d1_op_en;
    logic        dp_consumer, dp_start, dp_done;
    logic [1:0]  intr_done;
    cacc_fsm_e   dbg_fsm_state;

    always #5 clk = ~clk;

    nv_nvdla_cacc_regfile_ctrl dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .reg_offset     (reg_offset),
        .reg_wr_en      (reg_wr_en),
        .reg_wr_data    (reg_wr_data),
        .reg_rd_data    (reg_rd_data),
        .d0_reg_wr_en   (d0_reg_wr_en),
        .d1_reg_wr_en   (d1_reg_wr_en),
        .d0_rd_data     (d0_rd_data),
        .d1_rd_data     (d1_rd_data),
        .d0_op_en       (d0_op_en),
        .d1_op_en       (d1_op_en),
        .dp_consumer    (dp_consumer),
        .dp_start       (dp_start),
        .dp_done        (dp_done),
        .intr_done      (intr_done),
        .dbg_fsm_state  (dbg_fsm_state)
    );

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- reference model ----------------
    // m_age counts cycles the consumer has held its current layer
    // (0 = no layer; 1 = dp_start cycle; >=2 = dp_done is accepted).
    logic [1:0] m_en;
    logic       m_prod, m_cons, m_drop;
    int         m_age;
    logic [1:0] m_intr;

    function automatic logic [1:0] m_gstate(input int g);
        if (!m_en[g]) return 2'd0;
        if ((g == int'(m_cons)) && (m_age > 0)) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic m_is_dual(input logic [11:0] ofs);
        return (ofs >= 12'h00c) && (ofs <= 12'h034);
    endfunction

    function automatic logic [31:0] m_rd(input logic [11:0] ofs);
        logic [31:0] r;
        r = 32'd0;
        if (m_is_dual(ofs)) r = m_prod ? d1_rd_data : d0_rd_data;
        else if (ofs == 12'h000) begin
            r[1:0]   = m_gstate(0);
            r[17:16] = m_gstate(1);
            r[31]    = PROTECT && m_drop;
        end else if (ofs == 12'h004) begin
            r[0]  = m_prod;
            r[16] = m_cons;
        end
        return r;
    endfunction

    function automatic logic m_wr(input int g);
        return reg_wr_en && m_is_dual(reg_offset) && (int'(m_prod) == g) &&
               !(PROTECT && m_en[g]);
    endfunction

    task automatic model_step();
        logic       retire, launch;
        logic [1:0] en_n;
        if (rst) begin
            m_en = 2'b00; m_prod = 1'b0; m_cons = 1'b0; m_drop = 1'b0;
            m_age = 0; m_intr = 2'b00;
            return;
        end
        retire = (m_age >= 2) && dp_done;
        launch = (m_age == 0) && m_en[m_cons];
        en_n = m_en;
        if (reg_wr_en && reg_offset == 12'h008 && reg_wr_data[0] && !m_en[m_prod])
            en_n[m_prod] = 1'b1;
        if (retire) en_n[m_cons] = 1'b0;
        if (reg_wr_en && m_is_dual(reg_offset) && m_en[m_prod]) m_drop = 1'b1;
        else if (reg_wr_en && reg_offset == 12'h000 && reg_wr_data[31]) m_drop = 1'b0;
        if (reg_wr_en && reg_offset == 12'h004) m_prod = reg_wr_data[0];
        m_intr = retire ? (2'b01 << m_cons) : 2'b00;
        if (retire) m_age = 0;
        else if (launch) m_age = 1;
        else if (m_age > 0) m_age = m_age + 1;
        m_cons = m_cons ^ retire;
        m_en = en_n;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
        dp_done   = 1'b0;
    endtask

    task automatic wr(input logic [11:0] ofs, input logic [31:0] data);
        reg_offset  = ofs;
        reg_wr_data = data;
        reg_wr_en   = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++; if (d0_op_en !== 1'b0) begin n_bad++; $display("FAIL rst_d0_op_en: got %0b want 0", d0_op_en); end
        n_total++; if (d1_op_en !== 1'b0) begin n_bad++; $display("FAIL rst_d1_op_en: got %0b want 0", d1_op_en); end
        n_total++; if (dp_consumer !== 1'b0) begin n_bad++; $display("FAIL rst_consumer: got %0b want 0", dp_consumer); end
        n_total++; if (dp_start !== 1'b0) begin n_bad++; $display("FAIL rst_dp_start: got %0b want 0", dp_start); end
        n_total++; if (intr_done !== 2'b00) begin n_bad++; $display("FAIL rst_intr_done: got %b want 00", intr_done); end
        n_total++; if (dbg_fsm_state !== FSM_IDLE) begin n_bad++; $display("FAIL rst_fsm: got %0d want IDLE", dbg_fsm_state); end
        n_total++; if ({d0_reg_wr_en, d1_reg_wr_en} !== 2'b00) begin n_bad++; $display("FAIL rst_wr_en: got %b want 00", {d0_reg_wr_en, d1_reg_wr_en}); end
        reg_offset = 12'h000; #1;
        n_total++; if (reg_rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %h want 00000000", reg_rd_data); end
        reg_offset = 12'h004; #1;
        n_total++; if (reg_rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_pointer: got %h want 00000000", reg_rd_data); end
    endtask

    task automatic test_enable_done();
        do_reset();
        wr(12'h008, 32'h1);                    // now in T+1
        n_total++; if (d0_op_en !== 1'b1) begin n_bad++; $display("FAIL en_op_en_t1: got %0b want 1", d0_op_en); end
        n_total++; if (dp_start !== 1'b0) begin n_bad++; $display("FAIL en_start_t1: got %0b want 0", dp_start); end
        tick();                                 // T+2
        n_total++; if (dp_start !== 1'b1) begin n_bad++; $display("FAIL en_start_t2: got %0b want 1", dp_start); end
        reg_offset = 12'h000; #1;
        n_total++; if (reg_rd_data !== 32'h1) begin n_bad++; $display("FAIL en_status_run: got %h want 00000001", reg_rd_data); end
        tick();                                 // T+3
        n_total++; if (dp_start !== 1'b0) begin n_bad++; $display("FAIL en_start_t3: got %0b want 0", dp_start); end
        dp_done = 1'b1;
        tick();                                 // D+1
        n_total++; if (intr_done !== 2'b01) begin n_bad++; $display("FAIL done_intr: got %b want 01", intr_done); end
        n_total++; if (dp_consumer !== 1'b1) begin n_bad++; $display("FAIL done_consumer: got %0b want 1", dp_consumer); end
        n_total++; if (d0_op_en !== 1'b0) begin n_bad++; $display("FAIL done_op_en: got %0b want 0", d0_op_en); end
        reg_offset = 12'h000; #1;
        n_total++; if (reg_rd_data !== 32'h0) begin n_bad++; $display("FAIL done_status: got %h want 00000000", reg_rd_data); end
        tick();
        n_total++; if (intr_done !== 2'b00) begin n_bad++; $display("FAIL done_intr_pulse: got %b want 00", intr_done); end
    endtask

    task automatic test_ping_pong();
        do_reset();
        wr(12'h008, 32'h1);
        wr(12'h004, 32'h1);
        wr(12'h008, 32'h1);
        tick();
        reg_offset = 12'h004; #1;
        n_total++; if (reg_rd_data !== 32'h00000001) begin n_bad++; $display("FAIL pp_pointer_a: got %h want 00000001", reg_rd_data); end
        reg_offset = 12'h000; #1;
        n_total++; if (reg_rd_data !== 32'h00020001) begin n_bad++; $display("FAIL pp_status: got %h want 00020001", reg_rd_data); end
        dp_done = 1'b1;
        tick();                                 // D+1
        n_total++; if (intr_done !== 2'b01) begin n_bad++; $display("FAIL pp_intr0: got %b want 01", intr_done); end
        n_total++; if (dp_start !== 1'b0) begin n_bad++; $display("FAIL pp_start_d1: got %0b want 0", dp_start); end
        n_total++; if ({d1_op_en, d0_op_en} !== 2'b10) begin n_bad++; $display("FAIL pp_op_en: got %b want 10", {d1_op_en, d0_op_en}); end
        tick();                                 // D+2
        n_total++; if (dp_start !== 1'b1) begin n_bad++; $display("FAIL pp_start_d2: got %0b want 1", dp_start); end
        reg_offset = 12'h004; #1;
        n_total++; if (reg_rd_data !== 32'h00010001) begin n_bad++; $display("FAIL pp_pointer_b: got %h want 00010001", reg_rd_data); end
        tick();
        dp_done = 1'b1;
        tick();
        n_total++; if (intr_done !== 2'b10) begin n_bad++; $display("FAIL pp_intr1: got %b want 10", intr_done); end
        n_total++; if (dp_consumer !== 1'b0) begin n_bad++; $display("FAIL pp_consumer_wrap: got %0b want 0", dp_consumer); end
    endtask

    task automatic test_dual_write();
        logic [31:0] rd_a, rd_b;
        do_reset();
        wr(12'h008, 32'h1);
        tick();                                 // group 0 running
        reg_offset = 12'h010; reg_wr_data = 32'h0000abcd; reg_wr_en = 1'b1; #1;
        n_total++; if (d0_reg_wr_en !== !PROTECT) begin n_bad++; $display("FAIL dw_d0_wr_en: got %0b want %0b", d0_reg_wr_en, !PROTECT); end
        n_total++; if (d1_reg_wr_en !== 1'b0) begin n_bad++; $display("FAIL dw_d1_wr_en: got %0b want 0", d1_reg_wr_en); end
        tick();
        reg_offset = 12'h000; #1;
        n_total++; if (reg_rd_data !== {PROTECT, 31'h1}) begin n_bad++; $display("FAIL dw_status_drop: got %h want %h", reg_rd_data, {PROTECT, 31'h1}); end
        wr(12'h000, 32'h80000000);
        reg_offset = 12'h000; #1;
        n_total++; if (reg_rd_data !== 32'h1) begin n_bad++; $display("FAIL dw_drop_clear: got %h want 00000001", reg_rd_data); end
        rd_a = $urandom; rd_b = $urandom;
        d0_rd_data = rd_a; d1_rd_data = rd_b;
        reg_offset = 12'h034; #1;
        n_total++; if (reg_rd_data !== rd_a) begin n_bad++; $display("FAIL dw_rd_hi_bound: got %h want %h", reg_rd_data, rd_a); end
        reg_offset = 12'h038; reg_wr_en = 1'b1; #1;
        n_total++; if (reg_rd_data !== 32'h0) begin n_bad++; $display("FAIL dw_rd_out_range: got %h want 00000000", reg_rd_data); end
        n_total++; if ({d0_reg_wr_en, d1_reg_wr_en} !== 2'b00) begin n_bad++; $display("FAIL dw_wr_out_range: got %b want 00", {d0_reg_wr_en, d1_reg_wr_en}); end
        tick();
        wr(12'h004, 32'h1);                     // producer 1, group 1 idle
        reg_offset = 12'h00c; reg_wr_en = 1'b1; #1;
        n_total++; if ({d0_reg_wr_en, d1_reg_wr_en} !== 2'b01) begin n_bad++; $display("FAIL dw_wr_lo_bound_g1: got %b want 01", {d0_reg_wr_en, d1_reg_wr_en}); end
        n_total++; if (reg_rd_data !== rd_b) begin n_bad++; $display("FAIL dw_rd_g1: got %h want %h", reg_rd_data, rd_b); end
        tick();
    endtask

    task automatic test_ignored_done();
        do_reset();
        dp_done = 1'b1;
        tick();
        n_total++; if (intr_done !== 2'b00) begin n_bad++; $display("FAIL ig_idle_intr: got %b want 00", intr_done); end
        n_total++; if (dp_consumer !== 1'b0) begin n_bad++; $display("FAIL ig_idle_consumer: got %0b want 0", dp_consumer); end
        wr(12'h008, 32'h1);
        tick();                                 // dp_start cycle
        dp_done = 1'b1;
        tick();
        n_total++; if (intr_done !== 2'b00) begin n_bad++; $display("FAIL ig_start_intr: got %b want 00", intr_done); end
        n_total++; if (d0_op_en !== 1'b1) begin n_bad++; $display("FAIL ig_start_op_en: got %0b want 1", d0_op_en); end
        n_total++; if (dbg_fsm_state !== FSM_ACTIVE) begin n_bad++; $display("FAIL ig_start_fsm: got %0d want ACTIVE", dbg_fsm_state); end
        dp_done = 1'b1;
        tick();
        n_total++; if (intr_done !== 2'b01) begin n_bad++; $display("FAIL ig_later_intr: got %b want 01", intr_done); end
    endtask

    task automatic test_reset_mid_layer();
        do_reset();
        wr(12'h008, 32'h1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if ({d1_op_en, d0_op_en} !== 2'b00) begin n_bad++; $display("FAIL rm_op_en: got %b want 00", {d1_op_en, d0_op_en}); end
        n_total++; if (dbg_fsm_state !== FSM_IDLE) begin n_bad++; $display("FAIL rm_fsm: got %0d want IDLE", dbg_fsm_state); end
        n_total++; if (dp_consumer !== 1'b0) begin n_bad++; $display("FAIL rm_consumer: got %0b want 0", dp_consumer); end
        dp_done = 1'b1;
        tick();
        n_total++; if (intr_done !== 2'b00) begin n_bad++; $display("FAIL rm_done_intr: got %b want 00", intr_done); end
        n_total++; if (dp_consumer !== 1'b0) begin n_bad++; $display("FAIL rm_done_consumer: got %0b want 0", dp_consumer); end
    endtask

    task automatic test_random();
        logic [11:0] ofs_tab [10];
        logic [31:0] exp;
        ofs_tab[0] = 12'h000; ofs_tab[1] = 12'h004; ofs_tab[2] = 12'h008;
        ofs_tab[3] = 12'h00c; ofs_tab[4] = 12'h010; ofs_tab[5] = 12'h020;
        ofs_tab[6] = 12'h034; ofs_tab[7] = 12'h038; ofs_tab[8] = 12'h100;
        ofs_tab[9] = 12'hffc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reg_offset  = ofs_tab[$urandom_range(0, 9)];
            reg_wr_en   = ($urandom_range(0, 2) == 0);
            reg_wr_data = $urandom;
            if ($urandom_range(0, 1) == 1) reg_wr_data[0] = 1'b1;
            dp_done    = ($urandom_range(0, 3) == 0);
            d0_rd_data = $urandom;
            d1_rd_data = $urandom;
            #1;
            if (reg_offset != 12'h008) begin
                exp = m_rd(reg_offset);
                n_total++; if (reg_rd_data !== exp) begin n_bad++; $display("FAIL rnd_rd[%0d] ofs %h: got %h want %h", i, reg_offset, reg_rd_data, exp); end
            end
            n_total++; if ({d1_reg_wr_en, d0_reg_wr_en} !== {m_wr(1), m_wr(0)}) begin n_bad++; $display("FAIL rnd_wr_en[%0d]: got %b want %b", i, {d1_reg_wr_en, d0_reg_wr_en}, {m_wr(1), m_wr(0)}); end
            tick();
            n_total++; if ({d1_op_en, d0_op_en} !== m_en) begin n_bad++; $display("FAIL rnd_op_en[%0d]: got %b want %b", i, {d1_op_en, d0_op_en}, m_en); end
            n_total++; if (dp_start !== (m_age == 1)) begin n_bad++; $display("FAIL rnd_start[%0d]: got %0b want %0b", i, dp_start, (m_age == 1)); end
            n_total++; if (intr_done !== m_intr) begin n_bad++; $display("FAIL rnd_intr[%0d]: got %b want %b", i, intr_done, m_intr); end
            n_total++; if (dp_consumer !== m_cons) begin n_bad++; $display("FAIL rnd_consumer[%0d]: got %0b want %0b", i, dp_consumer, m_cons); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; reg_offset = 12'h0; reg_wr_en = 1'b0; reg_wr_data = 32'h0;
        d0_rd_data = 32'h0; d1_rd_data = 32'h0; dp_done = 1'b0;
        m_en = 2'b00; m_prod = 1'b0; m_cons = 1'b0; m_drop = 1'b0; m_age = 0; m_intr = 2'b00;
        test_reset();
        test_enable_done();
        test_ping_pong();
        test_dual_write();
        test_ignored_done();
        test_reset_mid_layer();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
